// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS31 definitions for the pattern generator and checker.
//            Holds the polynomial constants (x^31 + x^28 + 1), the checker
//            state encoding and the next-bit function used on both ends.
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    localparam int c_PRBS_LEN    = 31;
    localparam int c_PRBS_TAP_HI = 30;
    localparam int c_PRBS_TAP_LO = 27;

    // Encoding 3 is unused; the checker treats it as SEED on the next clock.
    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // Next bit of the sequence given the current register contents.
    function automatic logic prbs31_next_bit(input logic [c_PRBS_LEN-1:0] sr);
        return sr[c_PRBS_TAP_HI] ^ sr[c_PRBS_TAP_LO];
    endfunction

endpackage : prbs_pkg
`default_nettype wire

// File: rtl/prbs31_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_lfsr
// Purpose  : 31-bit PRBS31 shift register with prediction output.
//            On each enabled clock the register shifts in either the external
//            bit or its own predicted bit, so the same block serves as a
//            free-running generator or as a self-synchronising receiver.
// Ports    : clk        - clock (rising edge)
//            rst        - asynchronous active-high reset, clears the register
//            i_en       - shift enable
//            i_sel_pred - 1: shift in o_pred, 0: shift in i_din
//            i_din      - external bit to load
//            o_pred     - predicted next bit
//            o_sr       - current register contents
// Revision : 1.0 - initial release
// ============================================================================
module prbs31_lfsr
    import prbs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_sel_pred,
    input  logic                  i_din,
    output logic                  o_pred,
    output logic [c_PRBS_LEN-1:0] o_sr
);

    logic [c_PRBS_LEN-1:0] r_sr;
    logic                  w_pred;
    logic                  w_load;

    assign w_pred = prbs31_next_bit(r_sr);
    assign w_load = i_sel_pred ? w_pred : i_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= {r_sr[c_PRBS_LEN-2:0], w_load};
        end
    end

    assign o_pred = w_pred;
    assign o_sr   = r_sr;

endmodule : prbs31_lfsr
`default_nettype wire

// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_checker
// Purpose  : Serial PRBS31 checker. Seeds a local LFSR from 31 received bits,
//            verifies LOCK_CNT consecutive predictions, then free-runs and
//            counts bit errors. LOSS_ERRS errors inside one WIN_LEN-bit window
//            drop lock and restart seeding.
// Ports    : clk       - clock (rising edge)
//            rst_n     - asynchronous reset, ACTIVE HIGH despite the name
//            en        - bit-valid strobe
//            din       - received serial bit
//            clr_cnt   - synchronous clear of err_cnt
//            locked    - registered lock indication
//            err_pulse - one-cycle pulse per detected bit error
//            err_cnt   - saturating error count
//            state     - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 32,
    parameter int WIN_LEN   = 64,
    parameter int LOSS_ERRS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           state
);

    localparam int c_SEED_W  = $clog2(c_PRBS_LEN) + 1;
    localparam int c_MATCH_W = $clog2(LOCK_CNT) + 1;
    localparam int c_WIN_W   = $clog2(WIN_LEN) + 1;
    localparam int c_WERR_W  = $clog2(LOSS_ERRS) + 1;

    localparam logic [c_SEED_W-1:0]  c_SEED_LAST  = c_SEED_W'(c_PRBS_LEN - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LOCK = c_MATCH_W'(LOCK_CNT);
    localparam logic [c_WIN_W-1:0]   c_WIN_END    = c_WIN_W'(WIN_LEN);
    localparam logic [c_WERR_W-1:0]  c_WERR_LOSS  = c_WERR_W'(LOSS_ERRS);

    chk_state_t             r_state, w_state_nxt;
    logic [c_SEED_W-1:0]    r_seed_cnt, w_seed_nxt;
    logic [c_MATCH_W-1:0]   r_match_cnt, w_match_nxt;
    logic [c_WIN_W-1:0]     r_win_cnt, w_win_cnt_nxt;
    logic [c_WERR_W-1:0]    r_win_err, w_win_err_nxt;
    logic                   r_locked;
    logic                   r_err_pulse;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_pred;
    logic [c_PRBS_LEN-1:0]  w_sr;
    logic                   w_err;
    logic [c_MATCH_W-1:0]   w_match_inc;
    logic [c_WIN_W-1:0]     w_win_cnt_inc;
    logic [c_WERR_W-1:0]    w_win_err_inc;

    // While locked the register free-runs on its own prediction, so a single
    // flipped input bit produces exactly one error instead of three.
    prbs31_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst_n),
        .i_en       (en),
        .i_sel_pred (r_state == ST_LOCKED),
        .i_din      (din),
        .o_pred     (w_pred),
        .o_sr       (w_sr)
    );

    assign w_err         = en && (r_state == ST_LOCKED) && (din != w_pred);
    assign w_match_inc   = r_match_cnt + 1'b1;
    assign w_win_cnt_inc = r_win_cnt + 1'b1;
    assign w_win_err_inc = r_win_err + c_WERR_W'(w_err);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= ST_SEED;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_seed_cnt  <= w_seed_nxt;
            r_match_cnt <= w_match_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_err_pulse <= w_err;
            // Clear takes priority over a coincident error.
            if (clr_cnt) begin
                r_err_cnt <= '0;
            end else if (w_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seed_nxt    = r_seed_cnt;
        w_match_nxt   = r_match_cnt;
        w_win_cnt_nxt = r_win_cnt;
        w_win_err_nxt = r_win_err;
        case (r_state)
            ST_SEED: begin
                if (en) begin
                    if (r_seed_cnt == c_SEED_LAST) begin
                        w_state_nxt = ST_VERIFY;
                        w_seed_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_seed_nxt = r_seed_cnt + 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (en) begin
                    // An all-zero register predicts zeros forever; never
                    // count such matches toward lock.
                    if ((din == w_pred) && (|w_sr)) begin
                        if (w_match_inc == c_MATCH_LOCK) begin
                            w_state_nxt   = ST_LOCKED;
                            w_win_cnt_nxt = '0;
                            w_win_err_nxt = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (en) begin
                    // Loss is checked before the window wraps, so an error on
                    // the closing bit still belongs to the closing window.
                    if (w_win_err_inc == c_WERR_LOSS) begin
                        w_state_nxt = ST_SEED;
                        w_seed_nxt  = '0;
                    end else if (w_win_cnt_inc == c_WIN_END) begin
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = w_win_cnt_inc;
                        w_win_err_nxt = w_win_err_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEED;
                w_seed_nxt  = '0;
            end
        endcase
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign state     = r_state;

endmodule : prbs31_checker
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs31_checker
// Purpose  : Self-checking bench for prbs31_checker. A driver feeds directed
//            PRBS31 scenarios and pushes the expected post-edge outputs into a
//            queue; a monitor pops one entry each falling edge and compares.
//            A second instance with a 4-bit error counter shares the stimulus
//            to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs31_checker;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [1:0]  state;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        din;
    logic        clr_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;
    logic [1:0]  state4;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          idx   = 0;

    logic        e_locked;
    logic        e_pulse;
    logic [1:0]  e_state;
    int          e_cnt;
    int          lk;
    logic [30:0] g;

    always #5 clk = ~clk;

    prbs31_checker u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
    );

    prbs31_checker #(.ERR_CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .state(state4)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s entry=%0d got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    // Monitor: one expectation per falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("locked",    {15'd0, locked},    {15'd0, x.locked});
                chk("err_pulse", {15'd0, err_pulse}, {15'd0, x.pulse});
                chk("state",     {14'd0, state},     {14'd0, x.state});
                chk("err_cnt",   err_cnt,            x.cnt);
                chk("err_cnt4",  {12'd0, err_cnt4},  {12'd0, x.cnt4});
                idx++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    task automatic push_exp();
        exp_t x;
        x.locked = e_locked;
        x.pulse  = e_pulse;
        x.state  = e_state;
        x.cnt    = 16'(e_cnt);
        x.cnt4   = (e_cnt > 15) ? 4'd15 : 4'(e_cnt);
        q.push_back(x);
    endtask

    task automatic tick(input logic e, input logic d, input logic c);
        en      = e;
        din     = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
        push_exp();
    endtask

    task automatic next_stream(output logic b);
        b = g[30] ^ g[27];
        g = {g[29:0], b};
    endtask

    // n valid clean bits starting from SEED; lock expected on bit 63.
    task automatic acquire(input int n);
        logic b;
        for (int k = 1; k <= n; k++) begin
            e_state  = (k < 31) ? 2'd0 : ((k < 63) ? 2'd1 : 2'd2);
            e_locked = (k >= 63);
            e_pulse  = 1'b0;
            next_stream(b);
            tick(1'b1, b, 1'b0);
        end
        lk = 0;
    endtask

    // One bit while locked; flip corrupts it, lose marks the expected drop.
    task automatic lbit(input logic flip, input logic clr, input logic lose);
        logic b;
        e_pulse = flip;
        if (clr) e_cnt = 0;
        else if (flip) e_cnt++;
        if (lose) begin
            e_state  = 2'd0;
            e_locked = 1'b0;
        end else begin
            e_state  = 2'd2;
            e_locked = 1'b1;
        end
        lk++;
        next_stream(b);
        tick(1'b1, b ^ flip, clr);
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic do_reset();
        en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        e_state  = 2'd0;
        e_locked = 1'b0;
        e_pulse  = 1'b0;
        e_cnt    = 0;
        lk       = 0;
        #1;
        push_exp();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        push_exp();
    endtask

    initial begin
        int v;
        logic b;
        rst_n = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        g = 31'h7FFF_FFFF;
        e_state = 2'd0; e_locked = 1'b0; e_pulse = 1'b0; e_cnt = 0; lk = 0;
        @(posedge clk);
        #1;
        push_exp();
        rst_n = 1'b0;

        // Clean stream: lock on bit 63, no errors through 10,000 bits.
        acquire(63);
        for (int i = 0; i < 10000 - 63; i++) lbit(1'b0, 1'b0, 1'b0);

        // Single flipped bit: one pulse, count 1, lock held.
        for (int i = 1; i <= 400; i++) lbit(i == 200, 1'b0, 1'b0);

        // Clear coincident with an error: pulse still fires, count goes to 0.
        for (int i = 1; i <= 50; i++) lbit(i == 25, i == 25, 1'b0);

        // Eight errors in one window: lock lost on the 8th, then relock.
        while ((lk % 64) != 0) lbit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) lbit((i % 2) == 0, 1'b0, i == 14);
        acquire(63);

        // One error per window for 20 windows: 4-bit counter saturates.
        for (int w = 0; w < 20; w++)
            for (int p = 0; p < 64; p++) lbit(p == 10, 1'b0, 1'b0);

        // 8th error on the closing bit of a window still forces loss.
        for (int p = 0; p < 64; p++) lbit(p >= 56, 1'b0, p == 63);
        acquire(63);
        for (int i = 0; i < 20; i++) lbit(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while locked.
        do_reset();

        // All-zero input: reaches VERIFY, never locks.
        for (int k = 1; k <= 1000; k++) begin
            e_state  = (k < 31) ? 2'd0 : 2'd1;
            e_locked = 1'b0;
            e_pulse  = 1'b0;
            tick(1'b1, 1'b0, 1'b0);
        end

        // en alternating: lock after 63 valid bits (126 clocks).
        do_reset();
        v = 0;
        for (int c = 0; c < 126; c++) begin
            e_pulse = 1'b0;
            if ((c % 2) == 0) begin
                v++;
                e_state  = (v < 31) ? 2'd0 : ((v < 63) ? 2'd1 : 2'd2);
                e_locked = (v >= 63);
                next_stream(b);
                tick(1'b1, b, 1'b0);
            end else begin
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prbs31_checker
`default_nettype wire
